el2_dccm_mbist_ctrl: RTL

// Sits directly upstream of the DCCM memory wrapper. After reset the LSU drives the DCCM port through it combinationally.
// On start it takes over the port and runs a march test (or init-only) over every word of both lo/hi paths.
// It then reports pass/fail and leaves the array zero-initialised; all-zero is a valid SECDED codeword.

---
 rtl/el2_dccm_mbist_ctrl_if.sv | 29 ++
 rtl/el2_dccm_mbist_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/el2_dccm_mbist_ctrl_if.sv
// DCCM port bundle: write/read strobes, lo/hi addresses and data.
// master drives the request and receives read data; slave is the opposite.
interface el2_dccm_mbist_ctrl_if #(
  parameter int DCCM_BITS   = 16,
  parameter int FDATA_WIDTH = 39
);
  logic                   wren;
  logic                   rden;
  logic [DCCM_BITS-1:0]   wr_addr_lo;
  logic [DCCM_BITS-1:0]   wr_addr_hi;
  logic [DCCM_BITS-1:0]   rd_addr_lo;
  logic [DCCM_BITS-1:0]   rd_addr_hi;
  logic [FDATA_WIDTH-1:0] wr_data_lo;
  logic [FDATA_WIDTH-1:0] wr_data_hi;
  logic [FDATA_WIDTH-1:0] rd_data_lo;
  logic [FDATA_WIDTH-1:0] rd_data_hi;

  modport master (
    output wren, rden, wr_addr_lo, wr_addr_hi, rd_addr_lo, rd_addr_hi,
           wr_data_lo, wr_data_hi,
    input  rd_data_lo, rd_data_hi
  );

  modport slave (
    input  wren, rden, wr_addr_lo, wr_addr_hi, rd_addr_lo, rd_addr_hi,
           wr_data_lo, wr_data_hi,
    output rd_data_lo, rd_data_hi
  );
endinterface

// File: rtl/el2_dccm_mbist_ctrl.sv
// DCCM MBIST controller. Passes the LSU port straight through when idle;
// on start owns the port and runs W0(P) / R0 / W1(~P) descending / R1
// descending / CLR(0), or CLR alone for init_only. First mismatch is latched
// and ends the run early, leaving the array contents as they were.
module el2_dccm_mbist_ctrl #(
  parameter int                     DCCM_BITS   = 16,
  parameter int                     FDATA_WIDTH = 39,
  parameter int                     DEPTH       = 1 << (DCCM_BITS-2),
  parameter int                     RD_LATENCY  = 1,
  parameter logic [FDATA_WIDTH-1:0] PATTERN     = 39'h55_5555_5555
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   init_only,
  output logic                   busy,
  output logic                   done,
  output logic                   fail,
  output logic [DCCM_BITS-1:0]   fail_addr,
  output logic [FDATA_WIDTH-1:0] fail_data,
  el2_dccm_mbist_ctrl_if.slave   fn,
  el2_dccm_mbist_ctrl_if.master  dccm
);

  localparam int L    = RD_LATENCY;
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW   = (L > 1) ? $clog2(L) : 1;
  localparam logic [IW-1:0] LAST = IW'(DEPTH-1);
  localparam logic [DW-1:0] DLST = DW'(L-1);

  typedef enum logic [3:0] {
    S_IDLE, S_W0, S_R0, S_R0D, S_W1, S_R1, S_R1D, S_CLR, S_DONE
  } state_t;

  state_t                 state, state_nxt;
  logic [IW-1:0]          idx, idx_nxt;
  logic [DW-1:0]          dcnt, dcnt_nxt;
  logic                   own;
  logic                   wr, rd;
  logic [FDATA_WIDTH-1:0] wdata, rd_exp;
  logic [DCCM_BITS-1:0]   addr;
  logic                   mismatch;

  // Read tracking: valid / index / expected data, L stages deep.
  logic [L:1]             vld_pipe;
  logic [IW-1:0]          idx_pipe [1:L];
  logic [FDATA_WIDTH-1:0] exp_pipe [1:L];

  assign own  = (state != S_IDLE) && (state != S_DONE);
  assign busy = own;
  assign done = (state == S_DONE);
  assign addr = DCCM_BITS'({idx, 2'b00});

  // Return-cycle compare of both paths; only meaningful while in a read phase or its drain.
  assign mismatch = vld_pipe[L] &&
                    ((state == S_R0) || (state == S_R0D) || (state == S_R1) || (state == S_R1D)) &&
                    ((dccm.rd_data_lo != exp_pipe[L]) || (dccm.rd_data_hi != exp_pipe[L]));

  // Phase sequencing and per-cycle operation select.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    dcnt_nxt  = dcnt;
    wr        = 1'b0;
    rd        = 1'b0;
    wdata     = '0;
    rd_exp    = PATTERN;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = init_only ? S_CLR : S_W0;
          idx_nxt   = '0;
        end
      end
      S_W0: begin
        wr    = 1'b1;
        wdata = PATTERN;
        if (idx == LAST) begin
          state_nxt = S_R0;
          idx_nxt   = '0;
        end else idx_nxt = idx + IW'(1);
      end
      S_R0: begin
        rd = 1'b1;
        if (idx == LAST) begin
          state_nxt = S_R0D;
          dcnt_nxt  = '0;
        end else idx_nxt = idx + IW'(1);
      end
      S_R0D: begin
        if (dcnt == DLST) begin
          state_nxt = S_W1;
          idx_nxt   = LAST;
        end else dcnt_nxt = dcnt + DW'(1);
      end
      S_W1: begin
        wr    = 1'b1;
        wdata = ~PATTERN;
        if (idx == '0) begin
          state_nxt = S_R1;
          idx_nxt   = LAST;
        end else idx_nxt = idx - IW'(1);
      end
      S_R1: begin
        rd     = 1'b1;
        rd_exp = ~PATTERN;
        if (idx == '0) begin
          state_nxt = S_R1D;
          dcnt_nxt  = '0;
        end else idx_nxt = idx - IW'(1);
      end
      S_R1D: begin
        rd_exp = ~PATTERN;
        if (dcnt == DLST) begin
          state_nxt = S_CLR;
          idx_nxt   = '0;
        end else dcnt_nxt = dcnt + DW'(1);
      end
      S_CLR: begin
        wr = 1'b1;
        if (idx == LAST) state_nxt = S_DONE;
        else             idx_nxt   = idx + IW'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
    if (mismatch) state_nxt = S_DONE;
  end

  // State, index and drain counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  // Read tracking pipe; a mismatch discards everything still in flight.
  always_ff @(posedge clk) begin
    if (rst || mismatch) vld_pipe <= '0;
    else begin
      vld_pipe[1] <= rd;
      for (int k = 2; k <= L; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
    idx_pipe[1] <= idx;
    exp_pipe[1] <= rd_exp;
    for (int k = 2; k <= L; k++) begin
      idx_pipe[k] <= idx_pipe[k-1];
      exp_pipe[k] <= exp_pipe[k-1];
    end
  end

  // Result registers: cleared on an accepted start, first mismatch wins.
  always_ff @(posedge clk) begin
    if (rst || (!own && start)) begin
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
    end else if (mismatch && !fail) begin
      fail      <= 1'b1;
      fail_addr <= DCCM_BITS'({idx_pipe[L], 2'b00});
      fail_data <= dccm.rd_data_lo;
    end
  end

  // Port mux: LSU passthrough when idle/done, controller otherwise (hi mirrors lo).
  always_comb begin
    dccm.wren       = fn.wren;
    dccm.rden       = fn.rden;
    dccm.wr_addr_lo = fn.wr_addr_lo;
    dccm.wr_addr_hi = fn.wr_addr_hi;
    dccm.rd_addr_lo = fn.rd_addr_lo;
    dccm.rd_addr_hi = fn.rd_addr_hi;
    dccm.wr_data_lo = fn.wr_data_lo;
    dccm.wr_data_hi = fn.wr_data_hi;
    if (own) begin
      dccm.wren       = wr;
      dccm.rden       = rd;
      dccm.wr_addr_lo = addr;
      dccm.wr_addr_hi = addr;
      dccm.rd_addr_lo = addr;
      dccm.rd_addr_hi = addr;
      dccm.wr_data_lo = wdata;
      dccm.wr_data_hi = wdata;
    end
  end

  // Read data always returns straight to the LSU.
  assign fn.rd_data_lo = dccm.rd_data_lo;
  assign fn.rd_data_hi = dccm.rd_data_hi;

endmodule
